// File: rtl/hack_gate_sequencer.sv
// Sweeps every input vector of a small combinational gate, holds each one for
// SETTLE+1 cycles, and compares the gate output against a captured truth table.
module hack_gate_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   fail_mask,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail
);

  localparam int              NV        = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(NV - 1);
  localparam logic [3:0]      HOLD_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [3:0]      hold;
  logic [NV-1:0]   tt_q;
  logic            mismatch;

  assign mismatch = (dut_out != tt_q[idx]);

  // DONE behaves like IDLE for start acceptance, so sweeps can run back to back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      hold       <= '0;
      tt_q       <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy   <= 1'b0;
          dut_in <= '0;
          if (start) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            idx        <= '0;
            hold       <= '0;
            tt_q       <= exp_tt;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_count <= '0;
            first_fail <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
            idx    <= '0;
            hold   <= '0;
            pass   <= 1'b0;
          end else if (hold == HOLD_LAST) begin
            hold <= '0;
            if (mismatch) begin
              fail_mask[idx] <= 1'b1;
              fail_count     <= fail_count + 1'b1;
              if (fail_count == '0)
                first_fail <= idx;
            end
            // pass must account for the vector being sampled at this very edge
            if (idx == LAST_IDX) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              dut_in <= '0;
              idx    <= '0;
              pass   <= (fail_count == '0) && !mismatch;
            end else begin
              idx    <= idx + 1'b1;
              dut_in <= idx + 1'b1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
